// File: rtl/frac_clk_div_prog.sv
// frac_clk_div_prog
// Runtime-programmable fractional clock divider: f_out = f_in / (INT + FRAC/DEN).
// Each output period is INT or INT+1 clk_in cycles long. A first-order
// accumulator picks the length at the start of every period. Odd periods can
// hold the high phase for an extra half cycle through a negedge-registered copy.
// A new configuration goes into a shadow register first. It takes effect only at
// a period boundary, or straight away when the divider is idle.
module frac_clk_div_prog #(
    parameter int unsigned W        = 8,
    parameter int unsigned DEF_INT  = 8,
    parameter int unsigned DEF_FRAC = 7,
    parameter int unsigned DEF_DEN  = 10,
    parameter bit          ODD_HALF = 1'b1
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         enable_i,
    input  logic [W-1:0] cfg_int_i,
    input  logic [W-1:0] cfg_frac_i,
    input  logic [W-1:0] cfg_den_i,
    input  logic         cfg_load_i,
    output logic         cfg_ack_o,
    output logic         cfg_err_o,
    output logic         period_start_o,
    output logic         clk_out_o
);

    // Period length and accumulator need one extra bit (INT+1 may reach 2^W).
    localparam int unsigned PW = W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [W-1:0] int_part;
        logic [W-1:0] frac;
        logic [W-1:0] den;
    } cfg_t;

    localparam cfg_t DEF_CFG = {W'(DEF_INT), W'(DEF_FRAC), W'(DEF_DEN)};

    // A configuration is usable only if INT >= 2, DEN >= 1 and FRAC < DEN.
    function automatic logic cfg_valid(input cfg_t c);
        logic ok_int;
        logic ok_den;
        logic ok_frac;
        ok_int  = (c.int_part >= W'(2));
        ok_den  = (c.den >= W'(1));
        ok_frac = (c.frac < c.den);
        return ok_int & ok_den & ok_frac;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q,  state_d;
    logic [PW-1:0] cnt_q,    cnt_d;
    logic [PW-1:0] len_q,    len_d;
    logic [PW-1:0] acc_q,    acc_d;
    cfg_t          act_q,    act_d;
    cfg_t          shadow_q, shadow_d;
    logic          pend_q,   pend_d;
    logic          clk_hi_q, clk_hi_d;
    logic          ps_q,     ps_d;
    logic          ack_q,    ack_d;
    logic          err_q,    err_d;
    logic          alive_q;
    logic          neg_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic          last_s;
    logic          start_s;
    logic          apply_s;
    cfg_t          use_cfg_s;
    cfg_t          load_cfg_s;
    logic [PW-1:0] base_acc_s;
    logic [PW-1:0] sum_s;
    logic          long_s;

    assign last_s     = (cnt_q == (len_q - PW'(1)));
    assign load_cfg_s = {cfg_int_i, cfg_frac_i, cfg_den_i};

    // A period that starts together with a config apply uses the new
    // config and begins from a cleared accumulator.
    assign use_cfg_s  = apply_s ? shadow_q : act_q;
    assign base_acc_s = apply_s ? {PW{1'b0}} : acc_q;
    assign sum_s      = base_acc_s + {1'b0, use_cfg_s.frac};
    assign long_s     = (sum_s >= {1'b0, use_cfg_s.den});

    // FSM next state, and the period-start and config-apply decisions.
    always_comb begin
        state_d = state_q;
        start_s = 1'b0;
        apply_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // When idle, a pending config is applied on the next edge,
                // whether or not a period starts on that edge.
                apply_s = pend_q;
                if (enable_i) begin
                    start_s = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    if (enable_i) begin
                        start_s = 1'b1;
                        apply_s = pend_q;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Period datapath: cycle counter, chosen period length, accumulator and
    // active config.
    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        acc_d = acc_q;
        act_d = act_q;
        if (apply_s) begin
            act_d = shadow_q;
            acc_d = {PW{1'b0}};
        end else begin
            act_d = act_q;
        end
        if (start_s) begin
            cnt_d = {PW{1'b0}};
            len_d = {1'b0, use_cfg_s.int_part} + PW'(long_s);
            acc_d = long_s ? (sum_s - {1'b0, use_cfg_s.den}) : sum_s;
        end else if ((state_q == ST_RUN) && !last_s) begin
            cnt_d = cnt_q + PW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Shadow config capture, pending flag, and rejection of invalid loads.
    always_comb begin
        shadow_d = shadow_q;
        pend_d   = pend_q;
        err_d    = 1'b0;
        if (apply_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        if (cfg_load_i) begin
            if (cfg_valid(load_cfg_s)) begin
                shadow_d = load_cfg_s;
                pend_d   = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Next values of the registered outputs: high for the first floor(P/2) cycles.
    always_comb begin
        ps_d     = start_s;
        ack_d    = apply_s;
        clk_hi_d = 1'b0;
        if (state_d == ST_RUN) begin
            clk_hi_d = (cnt_d < {1'b0, len_d[PW-1:1]});
        end else begin
            clk_hi_d = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {PW{1'b0}};
            len_q    <= PW'(DEF_INT);
            acc_q    <= {PW{1'b0}};
            act_q    <= DEF_CFG;
            shadow_q <= DEF_CFG;
            pend_q   <= 1'b0;
            clk_hi_q <= 1'b0;
            ps_q     <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            alive_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            acc_q    <= acc_d;
            act_q    <= act_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            clk_hi_q <= clk_hi_d;
            ps_q     <= ps_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            alive_q  <= 1'b1;
        end
    end

    // Half-cycle extension: copy of the high phase for odd periods, taken on negedge.
    always_ff @(negedge clk_in) begin
        if (!rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= clk_hi_q & len_q[0] & ODD_HALF;
        end
    end

    // alive_q drops at the reset edge, so a pending half-cycle extension is
    // masked at once and no runt pulse is left before the next negedge.
    assign clk_out_o      = clk_hi_q | (neg_q & alive_q);
    assign period_start_o = ps_q;
    assign cfg_ack_o      = ack_q;
    assign cfg_err_o      = err_q;

endmodule
